// File: rtl/hilo_mdu.sv
// HI/LO multiply-divide unit: 32-cycle restoring divider plus a single-cycle multiplier.
// Define MDU_ITER_MUL_EN to replace the multiplier with a 32-cycle shift-add unit sharing the divider timing.
module hilo_mdu (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t      state, state_next;
    logic [4:0]  count;
    logic [31:0] mag_a, mag_b, work_hi, work_lo;
    logic        neg_res, neg_rem, op_is_div, by_zero;
    logic        accept, req_mul, req_div, req_signed;
    logic [31:0] in_mag_a, in_mag_b;
    logic [32:0] div_shift, div_diff, mul_sum;
    logic [63:0] raw_prod, fix_prod;
    logic [31:0] fix_quo, fix_rem;

    assign accept     = (state == IDLE) && start && !flush;
    assign req_mul    = (op[2:1] == 2'b00);
    assign req_div    = (op[2:1] == 2'b01);
    assign req_signed = !op[0];
    assign in_mag_a   = (req_signed && src_a[31]) ? -src_a : src_a;
    assign in_mag_b   = (req_signed && src_b[31]) ? -src_b : src_b;
    assign busy       = (state != IDLE);

    // Both iterative datapaths work on magnitudes; signs are restored in FIX.
    assign div_shift = {work_hi, work_lo[31]};
    assign div_diff  = div_shift - {1'b0, mag_b};
    assign mul_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, mag_a} : 33'd0);
    assign raw_prod  = {work_hi, work_lo};
    assign fix_prod  = neg_res ? -raw_prod : raw_prod;
    assign fix_quo   = neg_res ? -work_lo : work_lo;
    assign fix_rem   = neg_rem ? -work_hi : work_hi;

`ifndef MDU_ITER_MUL_EN
    logic [63:0] fast_prod;
    assign fast_prod = req_signed
        ? ($signed({{32{src_a[31]}}, src_a}) * $signed({{32{src_b[31]}}, src_b}))
        : ({32'd0, src_a} * {32'd0, src_b});
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept && req_div) state_next = DIV;
`ifdef MDU_ITER_MUL_EN
                if (accept && req_mul) state_next = MUL;
`endif
            end
            MUL, DIV: if (count == 5'd31) state_next = FIX;
            FIX:      state_next = IDLE;
            default:  state_next = IDLE;
        endcase
        if (flush) state_next = IDLE;
    end

    // Flush abandons the operation before any HI/LO write or done pulse can happen.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count     <= '0;
            mag_a     <= '0;
            mag_b     <= '0;
            work_hi   <= '0;
            work_lo   <= '0;
            neg_res   <= 1'b0;
            neg_rem   <= 1'b0;
            op_is_div <= 1'b0;
            by_zero   <= 1'b0;
            done      <= 1'b0;
            div_zero  <= 1'b0;
            hi_o      <= '0;
            lo_o      <= '0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            if (flush) begin
                count <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        count <= '0;
                        if (accept) begin
                            neg_res   <= req_signed && (src_a[31] ^ src_b[31]);
                            neg_rem   <= req_signed && src_a[31];
                            mag_a     <= in_mag_a;
                            mag_b     <= in_mag_b;
                            op_is_div <= req_div;
                            by_zero   <= (src_b == 32'd0);
                            case (op)
                                3'b100: hi_o <= src_a;
                                3'b101: lo_o <= src_a;
                                3'b010, 3'b011: begin
                                    work_hi <= '0;
                                    work_lo <= in_mag_a;
                                end
                                3'b000, 3'b001: begin
`ifdef MDU_ITER_MUL_EN
                                    work_hi <= '0;
                                    work_lo <= in_mag_b;
`else
                                    hi_o <= fast_prod[63:32];
                                    lo_o <= fast_prod[31:0];
                                    done <= 1'b1;
`endif
                                end
                                default: ;
                            endcase
                        end
                    end
                    DIV: begin
                        count <= count + 5'd1;
                        if (!div_diff[32]) begin
                            work_hi <= div_diff[31:0];
                            work_lo <= {work_lo[30:0], 1'b1};
                        end else begin
                            work_hi <= div_shift[31:0];
                            work_lo <= {work_lo[30:0], 1'b0};
                        end
                    end
                    MUL: begin
                        count   <= count + 5'd1;
                        work_hi <= mul_sum[32:1];
                        work_lo <= {mul_sum[0], work_lo[31:1]};
                    end
                    FIX: begin
                        done <= 1'b1;
                        if (op_is_div) begin
                            div_zero <= by_zero;
                            if (!by_zero) begin
                                lo_o <= fix_quo;
                                hi_o <= fix_rem;
                            end
                        end else begin
                            hi_o <= fix_prod[63:32];
                            lo_o <= fix_prod[31:0];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_hilo_mdu.sv
// Self-checking bench for hilo_mdu: a cycle-countdown reference model plus directed and random ops.
// Build with MDU_ITER_MUL_EN defined to check the iterative multiplier latency.
module tb_hilo_mdu;
    logic        clk = 1'b0, resetn = 1'b0, start = 1'b0, flush = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] src_a = 32'd0, src_b = 32'd0;
    logic        busy, done, div_zero;
    logic [31:0] hi_o, lo_o;

    int tests = 0;
    int fails = 0;

`ifdef MDU_ITER_MUL_EN
    localparam int MUL_LAT = 34;
`else
    localparam int MUL_LAT = 1;
`endif

    hilo_mdu dut (
        .clk(clk), .resetn(resetn), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b), .flush(flush),
        .busy(busy), .done(done), .div_zero(div_zero),
        .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    // Reference model: results come from plain arithmetic, timing from a busy-cycles-left counter.
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
    int          m_left = 0;
    logic        m_done = 1'b0, m_dz = 1'b0, pend_dz = 1'b0;
    logic [63:0] pend = 64'd0;

    function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint na, nb, q, r;
        logic [63:0] p;
        p = 64'd0;
        if (o == 3'd0) begin
            na = longint'($signed(a));
            nb = longint'($signed(b));
            p  = na * nb;
        end else if (o == 3'd1) begin
            p = {32'd0, a} * {32'd0, b};
        end else if (b != 32'd0) begin
            if (o == 3'd2) begin
                na = longint'($signed(a));
                nb = longint'($signed(b));
            end else begin
                na = longint'({32'd0, a});
                nb = longint'({32'd0, b});
            end
            q = na / nb;
            r = na % nb;
            p = {r[31:0], q[31:0]};
        end
        return p;
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_hi <= 32'd0; m_lo <= 32'd0; m_left <= 0;
            m_done <= 1'b0; m_dz <= 1'b0;
        end else begin
            m_done <= 1'b0;
            m_dz   <= 1'b0;
            if (flush) begin
                m_left <= 0;
            end else if (m_left > 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_done <= 1'b1;
                    m_dz   <= pend_dz;
                    if (!pend_dz) begin
                        m_hi <= pend[63:32];
                        m_lo <= pend[31:0];
                    end
                end
            end else if (start) begin
                case (op)
                    3'd4: m_hi <= src_a;
                    3'd5: m_lo <= src_a;
                    3'd0, 3'd1: begin
                        if (MUL_LAT == 1) begin
                            {m_hi, m_lo} <= ref_result(op, src_a, src_b);
                            m_done <= 1'b1;
                        end else begin
                            pend    <= ref_result(op, src_a, src_b);
                            pend_dz <= 1'b0;
                            m_left  <= 33;
                        end
                    end
                    3'd2, 3'd3: begin
                        pend    <= ref_result(op, src_a, src_b);
                        pend_dz <= (src_b == 32'd0);
                        m_left  <= 33;
                    end
                    default: ;
                endcase
            end
        end
    end

    task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_output();
        check_val("busy", busy, m_left > 0);
        check_val("done", done, m_done);
        check_val("div_zero", div_zero, m_dz);
        check_val("hi_o", hi_o, m_hi);
        check_val("lo_o", lo_o, m_lo);
    endtask

    always @(negedge clk) check_output();

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Requester holds start until busy is low, so the request lands on the next edge.
    task automatic apply_stimulus(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        int guard;
        guard = 0;
        start = 1'b1; op = o; src_a = a; src_b = b;
        while (busy && guard < 100) begin
            step();
            guard++;
        end
        check_val("accept_wait", busy, 1'b0);
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        while (!done && lat < 60) begin
            step();
            lat++;
        end
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (busy && guard < 60) begin
            step();
            guard++;
        end
        check_val("idle_wait", busy, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        logic [31:0] ra, rb;
        repeat (2) @(negedge clk);
        check_val("reset_hi", hi_o, 32'd0);
        check_val("reset_lo", lo_o, 32'd0);
        check_val("reset_busy", busy, 1'b0);
        #1;
        resetn = 1'b1;

        apply_stimulus(3'd4, 32'h12345678, 32'd0);
        check_val("mthi", hi_o, 32'h12345678);
        apply_stimulus(3'd5, 32'h9ABCDEF0, 32'd0);
        check_val("mtlo", lo_o, 32'h9ABCDEF0);
        check_val("mt_busy", busy, 1'b0);

        apply_stimulus(3'd3, 32'd100, 32'd7);
        wait_done(lat);
        check_val("divu_lat", lat, 34);
        check_val("divu_lo", lo_o, 32'd14);
        check_val("divu_hi", hi_o, 32'd2);

        apply_stimulus(3'd2, 32'hFFFFFF9C, 32'd7);
        wait_done(lat);
        check_val("div_neg_lo", lo_o, 32'hFFFFFFF2);
        check_val("div_neg_hi", hi_o, 32'hFFFFFFFE);

        apply_stimulus(3'd2, 32'h80000000, 32'hFFFFFFFF);
        wait_done(lat);
        check_val("div_ovf_lo", lo_o, 32'h80000000);
        check_val("div_ovf_hi", hi_o, 32'd0);

        apply_stimulus(3'd0, 32'hFFFFFFFF, 32'd2);
        wait_done(lat);
        check_val("mult_lat", lat, MUL_LAT);
        check_val("mult_hi", hi_o, 32'hFFFFFFFF);
        check_val("mult_lo", lo_o, 32'hFFFFFFFE);
        apply_stimulus(3'd1, 32'hFFFFFFFF, 32'd2);
        wait_done(lat);
        check_val("multu_lat", lat, MUL_LAT);
        check_val("multu_hi", hi_o, 32'd1);
        check_val("multu_lo", lo_o, 32'hFFFFFFFE);

        apply_stimulus(3'd4, 32'hAAAA0000, 32'd0);
        apply_stimulus(3'd5, 32'h0000BBBB, 32'd0);
        apply_stimulus(3'd3, 32'd5, 32'd0);
        wait_done(lat);
        check_val("dz_lat", lat, 34);
        check_val("dz_flag", div_zero, 1'b1);
        check_val("dz_hi", hi_o, 32'hAAAA0000);
        check_val("dz_lo", lo_o, 32'h0000BBBB);

        apply_stimulus(3'd2, 32'd1000, 32'd3);
        repeat (9) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check_val("flush_busy", busy, 1'b0);
        repeat (40) step();
        check_val("flush_hi", hi_o, 32'hAAAA0000);
        check_val("flush_lo", lo_o, 32'h0000BBBB);
        apply_stimulus(3'd3, 32'd9, 32'd3);
        wait_done(lat);
        check_val("post_flush_lo", lo_o, 32'd3);
        check_val("post_flush_hi", hi_o, 32'd0);

        apply_stimulus(3'd2, 32'd1000, 32'd3);
        repeat (19) step();
        resetn = 1'b0;
        step();
        step();
        check_val("midrst_hi", hi_o, 32'd0);
        check_val("midrst_lo", lo_o, 32'd0);
        check_val("midrst_busy", busy, 1'b0);
        resetn = 1'b1;
        repeat (40) step();
        apply_stimulus(3'd3, 32'd9, 32'd3);
        wait_done(lat);
        check_val("post_rst_lo", lo_o, 32'd3);
        check_val("post_rst_hi", hi_o, 32'd0);

        flush = 1'b1;
        apply_stimulus(3'd4, 32'hDEADBEEF, 32'd0);
        flush = 1'b0;
        check_val("flush_start_hi", hi_o, 32'd0);

        apply_stimulus(3'd3, 32'd50, 32'd5);
        repeat (4) step();
        apply_stimulus(3'd5, 32'h13572468, 32'd0);
        check_val("held_lo", lo_o, 32'h13572468);
        check_val("held_hi", hi_o, 32'd0);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0: ra = $urandom;
                1: ra = $urandom_range(0, 100);
                2: ra = 32'h80000000;
                default: ra = -$urandom_range(1, 100);
            endcase
            case ($urandom_range(0, 3))
                0: rb = $urandom;
                1: rb = $urandom_range(1, 20);
                2: rb = 32'd0;
                default: rb = -$urandom_range(1, 20);
            endcase
            apply_stimulus(3'($urandom_range(0, 7)), ra, rb);
            if ($urandom_range(0, 4) == 0) begin
                repeat ($urandom_range(0, 40)) step();
                flush = 1'b1;
                step();
                flush = 1'b0;
            end
            wait_idle();
            step();
        end

        repeat (3) step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
